// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN header reader: header word map, descriptor kinds, FSM states.
package cnn_pkg;

  localparam int HDR_FILTER_SIZE = 0;
  localparam int HDR_NUM_LAYERS  = 1;
  localparam int HDR_FILTER_OFF  = 2;
  localparam int HDR_DENSE_OFF   = 3;
  localparam int HDR_TABLE_BASE  = 4;

  typedef enum logic [1:0] {
    DK_FILT_CNT   = 2'd0,
    DK_FILT_TYPE  = 2'd1,
    DK_DENSE_CNT  = 2'd2,
    DK_WEIGHT_CNT = 2'd3
  } desc_kind_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HREQ,
    ST_HCAP,
    ST_CHECK,
    ST_BREQ,
    ST_BCAP,
    ST_EMIT,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/hdr_index_map.sv
// Maps a per-layer table index k (given N layers) to its descriptor kind and layer number.
module hdr_index_map
  import cnn_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int LAYER_W = 4
) (
  input  logic [ADDR_W-1:0]  idx_i,
  input  logic [ADDR_W-1:0]  num_i,
  output desc_kind_t         kind_o,
  output logic [LAYER_W-1:0] layer_o
);

  logic [ADDR_W-1:0] twoN;
  logic [ADDR_W-1:0] denseIdx;
  logic [ADDR_W-1:0] offset;

  assign twoN     = {num_i[ADDR_W-2:0], 1'b0};
  assign denseIdx = idx_i - twoN;

  // Dense region interleaves {dense count, weight count} per layer, so bit 0 picks the kind.
  always_comb begin
    kind_o = DK_FILT_CNT;
    offset = idx_i;
    if (idx_i < num_i) begin
      kind_o = DK_FILT_CNT;
      offset = idx_i;
    end else if (idx_i < twoN) begin
      kind_o = DK_FILT_TYPE;
      offset = idx_i - num_i;
    end else begin
      kind_o = denseIdx[0] ? DK_WEIGHT_CNT : DK_DENSE_CNT;
      offset = denseIdx >> 1;
    end
  end

  assign layer_o = LAYER_W'(offset);

endmodule

// File: rtl/cnn_header_reader.sv
// Fetches the four CNN header words from RAM, validates them, then streams one
// descriptor per per-layer table word over a valid/ready interface.
module cnn_header_reader
  import cnn_pkg::*;
#(
  parameter int MAX_LAYERS = 8,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int LAYER_W    = 4
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               start,
  output logic [ADDR_W-1:0]  ramAddress,
  output logic               readSignal,
  input  logic [DATA_W-1:0]  ramDataOut,
  output logic [DATA_W-1:0]  filterSize,
  output logic [DATA_W-1:0]  numLayers,
  output logic [DATA_W-1:0]  filterOffset,
  output logic [DATA_W-1:0]  denseOffset,
  output logic               desc_valid,
  input  logic               desc_ready,
  output logic [1:0]         desc_kind,
  output logic [LAYER_W-1:0] desc_layer,
  output logic [DATA_W-1:0]  desc_value,
  output logic               busy,
  output logic               done,
  output logic               error
);

  state_t              state_q, state_d;
  logic [1:0]          h_q, h_d;
  logic [ADDR_W-1:0]   k_q, k_d;
  logic [ADDR_W-1:0]   total_q, total_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   hdr_q [4];
  desc_kind_t          desc_kind_q;
  logic [LAYER_W-1:0]  desc_layer_q;
  logic [DATA_W-1:0]   desc_value_q;

  logic [ADDR_W-1:0]   nLayers;
  logic                hdrBad;
  desc_kind_t          mapKind;
  logic [LAYER_W-1:0]  mapLayer;

  assign nLayers = ADDR_W'(hdr_q[HDR_NUM_LAYERS]);
  assign hdrBad  = (hdr_q[HDR_NUM_LAYERS] == '0)
                || (hdr_q[HDR_NUM_LAYERS] > DATA_W'(MAX_LAYERS))
                || (hdr_q[HDR_DENSE_OFF] < hdr_q[HDR_FILTER_OFF]);

  hdr_index_map #(
    .ADDR_W (ADDR_W),
    .LAYER_W(LAYER_W)
  ) u_index_map (
    .idx_i  (k_q),
    .num_i  (nLayers),
    .kind_o (mapKind),
    .layer_o(mapLayer)
  );

  // The address is driven only in the request states and otherwise parks on the last value.
  always_comb begin
    state_d    = state_q;
    h_d        = h_q;
    k_d        = k_q;
    total_d    = total_q;
    readSignal = 1'b0;
    ramAddress = addr_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          h_d     = 2'd0;
          state_d = ST_HREQ;
        end
      end
      ST_HREQ: begin
        readSignal = 1'b1;
        ramAddress = ADDR_W'(h_q);
        state_d    = ST_HCAP;
      end
      ST_HCAP: begin
        if (h_q != 2'(HDR_DENSE_OFF)) begin
          h_d     = h_q + 2'd1;
          state_d = ST_HREQ;
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (hdrBad) begin
          state_d = ST_ERR;
        end else begin
          k_d     = '0;
          total_d = (nLayers << 2) - ADDR_W'(2);
          state_d = ST_BREQ;
        end
      end
      ST_BREQ: begin
        readSignal = 1'b1;
        ramAddress = ADDR_W'(HDR_TABLE_BASE) + k_q;
        state_d    = ST_BCAP;
      end
      ST_BCAP: state_d = ST_EMIT;
      ST_EMIT: begin
        if (desc_ready) begin
          k_d     = k_q + ADDR_W'(1);
          state_d = (k_q + ADDR_W'(1) == total_q) ? ST_DONE : ST_BREQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      h_q          <= '0;
      k_q          <= '0;
      total_q      <= '0;
      addr_q       <= '0;
      desc_kind_q  <= DK_FILT_CNT;
      desc_layer_q <= '0;
      desc_value_q <= '0;
      for (int i = 0; i < 4; i++) hdr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      k_q     <= k_d;
      total_q <= total_d;
      addr_q  <= ramAddress;
      if (state_q == ST_HCAP) hdr_q[h_q] <= ramDataOut;
      if (state_q == ST_BCAP) begin
        desc_value_q <= ramDataOut;
        desc_kind_q  <= mapKind;
        desc_layer_q <= mapLayer;
      end
    end
  end

  assign filterSize   = hdr_q[HDR_FILTER_SIZE];
  assign numLayers    = hdr_q[HDR_NUM_LAYERS];
  assign filterOffset = hdr_q[HDR_FILTER_OFF];
  assign denseOffset  = hdr_q[HDR_DENSE_OFF];
  assign desc_valid   = (state_q == ST_EMIT);
  assign desc_kind    = desc_kind_q;
  assign desc_layer   = desc_layer_q;
  assign desc_value   = desc_value_q;
  assign busy         = !((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
  assign done         = (state_q == ST_DONE);
  assign error        = (state_q == ST_ERR);

endmodule

// File: tb/tb_cnn_header_reader.sv
// Directed bench for cnn_header_reader: 1-cycle-latency RAM model, descriptor monitor, hand-computed expectations.
module tb_cnn_header_reader;

  logic        clk = 1'b0;
  logic        RST;
  logic        start;
  logic [15:0] ramAddress;
  logic        readSignal;
  logic [15:0] ramDataOut;
  logic [15:0] filterSize, numLayers, filterOffset, denseOffset;
  logic        desc_valid;
  logic        desc_ready;
  logic [1:0]  desc_kind;
  logic [3:0]  desc_layer;
  logic [15:0] desc_value;
  logic        busy, done, error;

  cnn_header_reader dut (
    .clk         (clk),
    .RST         (RST),
    .start       (start),
    .ramAddress  (ramAddress),
    .readSignal  (readSignal),
    .ramDataOut  (ramDataOut),
    .filterSize  (filterSize),
    .numLayers   (numLayers),
    .filterOffset(filterOffset),
    .denseOffset (denseOffset),
    .desc_valid  (desc_valid),
    .desc_ready  (desc_ready),
    .desc_kind   (desc_kind),
    .desc_layer  (desc_layer),
    .desc_value  (desc_value),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:63];
  always @(posedge clk) if (readSignal) ramDataOut <= mem[ramAddress[5:0]];

  int checks = 0;
  int errors = 0;
  logic [21:0] gotQ[$];
  logic [21:0] expQ[$];
  int  validSeen = 0;
  int  stabErr = 0;
  int  readInEmit = 0;
  bit  holdPending = 0;
  logic [21:0] heldDesc;
  bit  randomReady = 0;

  // Descriptor monitor: records handshakes and flags any change of a stalled descriptor.
  always @(negedge clk) begin
    if (!RST) begin
      if (desc_valid) begin
        validSeen++;
        if (readSignal) readInEmit++;
        if (holdPending && {desc_kind, desc_layer, desc_value} != heldDesc) stabErr++;
        if (desc_ready) begin
          gotQ.push_back({desc_kind, desc_layer, desc_value});
          holdPending = 0;
        end else begin
          holdPending = 1;
          heldDesc = {desc_kind, desc_layer, desc_value};
        end
      end else begin
        holdPending = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (randomReady) desc_ready = 1'($urandom_range(0, 1));
    end
  end

  function automatic logic [21:0] mk(input int kind, input int layer, input int value);
    return {kind[1:0], layer[3:0], value[15:0]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkSequence(input string tag);
    checkOutput({tag, " count"}, gotQ.size(), expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      logic [21:0] g;
      g = (i < gotQ.size()) ? gotQ[i] : 22'h3fffff;
      checkOutput($sformatf("%s desc%0d", tag, i), {10'd0, g}, {10'd0, expQ[i]});
    end
  endtask

  task automatic loadImage(input logic [15:0] w [14]);
    for (int i = 0; i < 64; i++) mem[i] = 16'd0;
    for (int i = 0; i < 14; i++) mem[i] = w[i];
  endtask

  task automatic expectMain();
    expQ.delete();
    expQ.push_back(mk(0, 0, 6));  expQ.push_back(mk(0, 1, 6));  expQ.push_back(mk(0, 2, 6));
    expQ.push_back(mk(1, 0, 0));  expQ.push_back(mk(1, 1, 1));  expQ.push_back(mk(1, 2, 1));
    expQ.push_back(mk(2, 0, 12)); expQ.push_back(mk(3, 0, 12));
    expQ.push_back(mk(2, 1, 12)); expQ.push_back(mk(3, 1, 12));
  endtask

  // Pulses start, then counts edges until done/error; midStart re-pulses start at that edge count.
  task automatic applyStimulus(input int budget, input int midStart, output int cycles,
                               output bit timedOut, output bit doneAfter, output bit busyAfter);
    gotQ.delete();
    validSeen = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    doneAfter = done;
    busyAfter = busy;
    cycles = 0;
    timedOut = 1;
    for (int i = 0; i < budget; i++) begin
      start = (cycles == midStart);
      @(posedge clk);
      #1;
      cycles++;
      if (done || error) begin
        timedOut = 0;
        break;
      end
    end
    start = 1'b0;
  endtask

  int cycles;
  bit timedOut, doneAfter, busyAfter;
  logic [15:0] mainImg [14] = '{16'd1, 16'd3, 16'd14, 16'd50, 16'd6, 16'd6, 16'd6,
                                16'd0, 16'd1, 16'd1, 16'd12, 16'd12, 16'd12, 16'd12};
  logic [15:0] img [14];

  initial begin
    RST = 1'b1;
    start = 1'b0;
    desc_ready = 1'b1;
    loadImage(mainImg);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset error", error, 0);
    checkOutput("reset valid", desc_valid, 0);
    checkOutput("reset read", readSignal, 0);
    checkOutput("reset addr", ramAddress, 0);
    checkOutput("reset numLayers", numLayers, 0);
    @(negedge clk);
    RST = 1'b0;

    $display("[TB] main image, ready held high");
    expectMain();
    applyStimulus(200, -1, cycles, timedOut, doneAfter, busyAfter);
    checkOutput("main timeout", timedOut, 0);
    checkOutput("main busy after start", busyAfter, 1);
    checkOutput("main cycles", cycles, 39);
    checkOutput("main filterSize", filterSize, 1);
    checkOutput("main numLayers", numLayers, 3);
    checkOutput("main filterOffset", filterOffset, 14);
    checkOutput("main denseOffset", denseOffset, 50);
    checkOutput("main done", done, 1);
    checkOutput("main busy end", busy, 0);
    checkOutput("main error", error, 0);
    checkSequence("main");

    $display("[TB] main image, random ready");
    stabErr = 0;
    readInEmit = 0;
    randomReady = 1;
    applyStimulus(2000, -1, cycles, timedOut, doneAfter, busyAfter);
    randomReady = 0;
    @(negedge clk);
    desc_ready = 1'b1;
    checkOutput("rand timeout", timedOut, 0);
    checkOutput("rand done", done, 1);
    checkOutput("rand stable", stabErr, 0);
    checkOutput("rand read in emit", readInEmit, 0);
    checkSequence("rand");

    $display("[TB] illegal headers");
    for (int t = 0; t < 3; t++) begin
      img = mainImg;
      if (t == 0) img[1] = 16'd0;
      if (t == 1) img[1] = 16'd9;
      if (t == 2) begin img[2] = 16'd50; img[3] = 16'd14; end
      loadImage(img);
      applyStimulus(200, -1, cycles, timedOut, doneAfter, busyAfter);
      checkOutput($sformatf("err%0d timeout", t), timedOut, 0);
      checkOutput($sformatf("err%0d cycles", t), cycles, 9);
      checkOutput($sformatf("err%0d error", t), error, 1);
      checkOutput($sformatf("err%0d done", t), done, 0);
      checkOutput($sformatf("err%0d busy", t), busy, 0);
      checkOutput($sformatf("err%0d valid seen", t), validSeen, 0);
    end

    $display("[TB] single layer");
    img = mainImg;
    img[1] = 16'd1;
    img[4] = 16'd8;
    img[5] = 16'd0;
    loadImage(img);
    expQ.delete();
    expQ.push_back(mk(0, 0, 8));
    expQ.push_back(mk(1, 0, 0));
    applyStimulus(200, -1, cycles, timedOut, doneAfter, busyAfter);
    checkOutput("n1 timeout", timedOut, 0);
    checkOutput("n1 done", done, 1);
    checkOutput("n1 cycles", cycles, 15);
    checkSequence("n1");

    $display("[TB] reset during fifth descriptor");
    loadImage(mainImg);
    gotQ.delete();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    timedOut = 1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #2;
      if (desc_valid && gotQ.size() == 4) begin
        timedOut = 0;
        break;
      end
    end
    checkOutput("rst5 reached", timedOut, 0);
    RST = 1'b1;
    #1;
    checkOutput("rst5 valid", desc_valid, 0);
    checkOutput("rst5 busy", busy, 0);
    checkOutput("rst5 read", readSignal, 0);
    checkOutput("rst5 addr", ramAddress, 0);
    checkOutput("rst5 value", desc_value, 0);
    checkOutput("rst5 denseOffset", denseOffset, 0);
    @(negedge clk);
    RST = 1'b0;
    expectMain();
    applyStimulus(200, -1, cycles, timedOut, doneAfter, busyAfter);
    checkOutput("restart cycles", cycles, 39);
    checkSequence("restart");

    $display("[TB] start while busy, then start in done");
    applyStimulus(200, 20, cycles, timedOut, doneAfter, busyAfter);
    checkOutput("busy start cycles", cycles, 39);
    checkSequence("busy start");
    applyStimulus(200, -1, cycles, timedOut, doneAfter, busyAfter);
    checkOutput("rerun done cleared", doneAfter, 0);
    checkOutput("rerun busy", busyAfter, 1);
    checkOutput("rerun cycles", cycles, 39);
    checkOutput("rerun done", done, 1);
    checkSequence("rerun");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
